// File: rtl/ram_block_copier_pkg.sv
// Shared constants and types for the RAM block copier: widths, FSM encodings
// and the RAM port bundle driven toward the single-port data RAM.
package ram_block_copier_pkg;

  localparam int AW      = 5;
  localparam int DW      = 32;
  localparam int RAM_AW  = 32;
  localparam int DEPTH   = 1 << AW;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RD   = 2'd1;
  localparam state_t ST_WR   = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  typedef struct packed {
    logic [RAM_AW-1:0] addr;
    logic              we;
    logic [DW-1:0]     wdata;
  } ram_port_t;

  function automatic logic [RAM_AW-1:0] zext_addr(input logic [AW-1:0] a);
    return {{(RAM_AW - AW){1'b0}}, a};
  endfunction

endpackage

// File: rtl/ram_block_copier_if.sv
// Control and RAM-port bundle of the block copier; the copier is the master,
// the controller/RAM side is the slave.
interface ram_block_copier_if
  import ram_block_copier_pkg::*;
  ();

  logic              start;
  logic [AW-1:0]     src_base;
  logic [AW-1:0]     dst_base;
  logic [AW:0]       len;
  logic              busy;
  logic              done;
  logic [DW-1:0]     checksum;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;
  logic [DW-1:0]     ram_wdata;
  logic [DW-1:0]     ram_rdata;

  modport master (
    input  start, src_base, dst_base, len, ram_rdata,
    output busy, done, checksum, ram_addr, ram_we, ram_wdata
  );

  modport slave (
    output start, src_base, dst_base, len, ram_rdata,
    input  busy, done, checksum, ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/ram_block_copier_addr_gen.sv
// Word-offset walker for the copier: holds bases, offset k, copy direction and
// the remaining-word count; produces wrapped source/destination addresses.
module ram_block_copier_addr_gen
  import ram_block_copier_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [AW-1:0] src_base_i,
  input  logic [AW-1:0] dst_base_i,
  input  logic [AW:0]   len_i,
  input  logic          step_i,
  output logic [AW-1:0] src_addr_o,
  output logic [AW-1:0] dst_addr_o,
  output logic          last_o
);

  localparam logic [AW:0] ONE = (AW + 1)'(1);

  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW:0]   remain_q, remain_d;
  logic          desc_q, desc_d;

  logic [AW-1:0] diff;
  logic [AW:0]   len_m1;
  logic          desc_new;

  // Copy downward when the destination lands inside the source window ahead of
  // it, so overlapping moves never read a word they already overwrote.
  assign diff     = dst_base_i - src_base_i;
  assign desc_new = (diff != '0) && ({1'b0, diff} < len_i);
  assign len_m1   = len_i - ONE;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    k_d      = k_q;
    remain_d = remain_q;
    desc_d   = desc_q;
    if (load_i) begin
      src_d    = src_base_i;
      dst_d    = dst_base_i;
      remain_d = len_i;
      desc_d   = desc_new;
      k_d      = desc_new ? len_m1[AW-1:0] : '0;
    end else if (step_i) begin
      k_d      = desc_q ? (k_q - 1'b1) : (k_q + 1'b1);
      remain_d = remain_q - ONE;
    end
  end

  // NOTE: state registers update with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q    <= '0;
      dst_q    <= '0;
      k_q      <= '0;
      remain_q <= '0;
      desc_q   <= 1'b0;
    end else begin
      src_q    <= src_d;
      dst_q    <= dst_d;
      k_q      <= k_d;
      remain_q <= remain_d;
      desc_q   <= desc_d;
    end
  end

  assign src_addr_o = src_q + k_q;
  assign dst_addr_o = dst_q + k_q;
  assign last_o     = (remain_q == ONE);

endmodule

// File: rtl/ram_block_copier.sv
// RAM block copier: moves len words from src_base to dst_base in the shared
// data RAM (memmove semantics, two cycles per word) while summing the words read.
module ram_block_copier
  import ram_block_copier_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  ram_block_copier_if.master  bus
);

  state_t        state_q, state_d;
  logic [DW-1:0] checksum_q, checksum_d;
  logic [DW-1:0] data_q, data_d;

  logic          accept;
  logic          step;
  logic          last;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  ram_port_t     port;

  assign accept = (state_q == ST_IDLE) && bus.start;
  assign step   = (state_q == ST_WR) && !last;

  ram_block_copier_addr_gen u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .src_base_i (bus.src_base),
    .dst_base_i (bus.dst_base),
    .len_i      (bus.len),
    .step_i     (step),
    .src_addr_o (src_addr),
    .dst_addr_o (dst_addr),
    .last_o     (last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = (bus.len == '0) ? ST_DONE : ST_RD;
      ST_RD:   state_d = ST_WR;
      ST_WR:   state_d = last ? ST_DONE : ST_RD;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    checksum_d = checksum_q;
    data_d     = data_q;
    if (accept) begin
      checksum_d = '0;
    end else if (state_q == ST_RD) begin
      checksum_d = checksum_q + bus.ram_rdata;
      data_d     = bus.ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      checksum_q <= checksum_d;
    end
  end

  // NOTE: the word buffer is pure datapath, always loaded in RD before WR
  // consumes it, so it carries no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  // Write enable is also gated by rst_n so a reset landing on a WR edge
  // suppresses that write instead of letting the RAM commit it.
  always_comb begin
    port = '0;
    case (state_q)
      ST_RD: port.addr = zext_addr(src_addr);
      ST_WR: begin
        port.addr  = zext_addr(dst_addr);
        port.we    = rst_n;
        port.wdata = data_q;
      end
      default: port = '0;
    endcase
  end

  assign bus.ram_addr  = port.addr;
  assign bus.ram_we    = port.we;
  assign bus.ram_wdata = port.wdata;
  assign bus.busy      = (state_q == ST_RD) || (state_q == ST_WR);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.checksum  = checksum_q;

endmodule

// File: tb/tb_ram_block_copier.sv
// Directed bench for ram_block_copier with a 32x32 RAM model reloaded to the
// power-up image before each scenario.
module tb_ram_block_copier;
  import ram_block_copier_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic load_req = 1'b0;
  always #5 clk = ~clk;

  ram_block_copier_if bus ();

  ram_block_copier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem [DEPTH];

  function automatic logic [DW-1:0] image(input int i);
    case (i)
      0:       return 32'hBF80_0000;
      20:      return 32'h0000_00A3;
      21:      return 32'h0000_0027;
      22:      return 32'h0000_0079;
      23:      return 32'h0000_0115;
      default: return DW'(i);
    endcase
  endfunction

  assign bus.ram_rdata = mem[bus.ram_addr[AW-1:0]];

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= image(i);
    end else if (bus.ram_we) begin
      mem[bus.ram_addr[AW-1:0]] <= bus.ram_wdata;
    end
  end

  int we_cnt = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  logic [AW-1:0] wr_log [$];

  always @(negedge clk) begin
    if (bus.ram_we === 1'b1) begin
      we_cnt++;
      wr_log.push_back(bus.ram_addr[AW-1:0]);
    end
    if (bus.done === 1'b1) done_cnt++;
    if (bus.busy === 1'b1) busy_cnt++;
  end

  int checks = 0;
  int fails = 0;

  task automatic load_image();
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  task automatic start_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                            input logic [AW:0] n);
    bus.src_base = src;
    bus.dst_base = dst;
    bus.len      = n;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.src_base = ~src;
    bus.dst_base = ~dst;
    bus.len      = 6'd7;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.src_base = '0;
    bus.dst_base = '0;
    bus.len = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.checksum !== 32'h0) begin fails++; $display("FAIL reset_checksum got %h want 0", bus.checksum); end
    checks++; if (bus.ram_we !== 1'b0) begin fails++; $display("FAIL reset_we got %b want 0", bus.ram_we); end
    checks++; if (bus.ram_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h want 0", bus.ram_addr); end
    checks++; if (bus.ram_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata got %h want 0", bus.ram_wdata); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, we0, d0, qi;
    logic [DW-1:0] exp_v [4];
    exp_v = '{32'hA3, 32'h27, 32'h79, 32'h115};
    load_image();
    we0 = we_cnt; d0 = done_cnt; qi = wr_log.size();
    start_copy(5'h14, 5'h00, 6'd4);
    wait_done(lat);
    checks++; if (lat != 8) begin fails++; $display("FAIL basic_latency got %0d want 8", lat); end
    checks++; if (bus.checksum !== 32'h258) begin fails++; $display("FAIL basic_checksum got %h want 258", bus.checksum); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got %b want 0", bus.done); end
    checks++; if (bus.checksum !== 32'h258) begin fails++; $display("FAIL basic_checksum_hold got %h want 258", bus.checksum); end
    checks++; if (we_cnt - we0 != 4) begin fails++; $display("FAIL basic_we_count got %0d want 4", we_cnt - we0); end
    checks++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL basic_done_count got %0d want 1", done_cnt - d0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem[i] !== exp_v[i]) begin fails++; $display("FAIL basic_mem[%0d] got %h want %h", i, mem[i], exp_v[i]); end
      checks++; if (wr_log[qi+i] !== AW'(i)) begin fails++; $display("FAIL basic_wr_addr[%0d] got %0d want %0d", i, wr_log[qi+i], i); end
    end
  endtask

  task automatic test_overlap_fwd();
    int lat, qi;
    logic [DW-1:0] exp_v [4];
    logic [AW-1:0] exp_a [3];
    exp_v = '{32'd2, 32'd2, 32'd3, 32'd4};
    exp_a = '{5'd5, 5'd4, 5'd3};
    load_image();
    qi = wr_log.size();
    start_copy(5'h02, 5'h03, 6'd3);
    wait_done(lat);
    checks++; if (lat != 6) begin fails++; $display("FAIL overlap_latency got %0d want 6", lat); end
    checks++; if (bus.checksum !== 32'd9) begin fails++; $display("FAIL overlap_checksum got %h want 9", bus.checksum); end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem[i+2] !== exp_v[i]) begin fails++; $display("FAIL overlap_mem[%0d] got %h want %h", i + 2, mem[i+2], exp_v[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (wr_log[qi+i] !== exp_a[i]) begin fails++; $display("FAIL overlap_wr_addr[%0d] got %0d want %0d", i, wr_log[qi+i], exp_a[i]); end
    end
  endtask

  task automatic test_wrap();
    int lat;
    logic [DW-1:0] exp_v [4];
    exp_v = '{32'h1E, 32'h1F, 32'hBF80_0000, 32'h01};
    load_image();
    start_copy(5'h1E, 5'h00, 6'd4);
    wait_done(lat);
    checks++; if (lat != 8) begin fails++; $display("FAIL wrap_latency got %0d want 8", lat); end
    checks++; if (bus.checksum !== 32'hBF80_003E) begin fails++; $display("FAIL wrap_checksum got %h want BF80003E", bus.checksum); end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem[i] !== exp_v[i]) begin fails++; $display("FAIL wrap_mem[%0d] got %h want %h", i, mem[i], exp_v[i]); end
    end
  endtask

  task automatic test_len0();
    int lat, we0, b0;
    we0 = we_cnt; b0 = busy_cnt;
    start_copy(5'h03, 5'h07, 6'd0);
    wait_done(lat);
    checks++; if (lat != 0) begin fails++; $display("FAIL len0_latency got %0d want 0", lat); end
    checks++; if (bus.checksum !== 32'h0) begin fails++; $display("FAIL len0_checksum got %h want 0", bus.checksum); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL len0_done_pulse got %b want 0", bus.done); end
    checks++; if (busy_cnt != b0) begin fails++; $display("FAIL len0_busy got %0d busy cycles want 0", busy_cnt - b0); end
    checks++; if (we_cnt != we0) begin fails++; $display("FAIL len0_we got %0d writes want 0", we_cnt - we0); end
  endtask

  task automatic test_start_busy();
    int lat, we0, d0;
    load_image();
    we0 = we_cnt; d0 = done_cnt;
    start_copy(5'h14, 5'h00, 6'd4);
    repeat (2) begin @(posedge clk); #1; end
    bus.src_base = 5'h08;
    bus.dst_base = 5'h10;
    bus.len      = 6'd2;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    wait_done(lat);
    checks++; if (lat != 5) begin fails++; $display("FAIL busy_latency got %0d want 5", lat); end
    repeat (8) begin @(posedge clk); #1; end
    checks++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL busy_done_count got %0d want 1", done_cnt - d0); end
    checks++; if (we_cnt - we0 != 4) begin fails++; $display("FAIL busy_we_count got %0d want 4", we_cnt - we0); end
    checks++; if (mem[16] !== 32'd16 || mem[17] !== 32'd17) begin fails++; $display("FAIL busy_dst2 got %h %h want 10 11", mem[16], mem[17]); end
    checks++; if (mem[3] !== 32'h115) begin fails++; $display("FAIL busy_mem3 got %h want 115", mem[3]); end
  endtask

  task automatic test_reset_mid();
    int we0, d0;
    load_image();
    we0 = we_cnt; d0 = done_cnt;
    start_copy(5'h14, 5'h00, 6'd4);
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 32'd2) begin fails++; $display("FAIL rstmid_in_wr2 got we=%b addr=%0d want we=1 addr=2", bus.ram_we, bus.ram_addr); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    checks++; if (bus.ram_we !== 1'b0) begin fails++; $display("FAIL rstmid_we got %b want 0", bus.ram_we); end
    checks++; if (bus.checksum !== 32'h0) begin fails++; $display("FAIL rstmid_checksum got %h want 0", bus.checksum); end
    repeat (6) begin @(posedge clk); #1; end
    checks++; if (mem[0] !== 32'hA3 || mem[1] !== 32'h27) begin fails++; $display("FAIL rstmid_written got %h %h want A3 27", mem[0], mem[1]); end
    checks++; if (mem[2] !== 32'h2) begin fails++; $display("FAIL rstmid_word2 got %h want 2", mem[2]); end
    checks++; if (we_cnt - we0 != 2) begin fails++; $display("FAIL rstmid_we_count got %0d want 2", we_cnt - we0); end
    checks++; if (done_cnt != d0) begin fails++; $display("FAIL rstmid_done got %0d pulses want 0", done_cnt - d0); end
  endtask

  task automatic test_full_len32();
    int lat, we0, qi, bad;
    load_image();
    we0 = we_cnt; qi = wr_log.size(); bad = 0;
    start_copy(5'h05, 5'h05, 6'd32);
    wait_done(lat);
    checks++; if (lat != 64) begin fails++; $display("FAIL full_latency got %0d want 64", lat); end
    checks++; if (bus.checksum !== 32'hBF80_03F2) begin fails++; $display("FAIL full_checksum got %h want BF8003F2", bus.checksum); end
    @(posedge clk); #1;
    checks++; if (we_cnt - we0 != 32) begin fails++; $display("FAIL full_we_count got %0d want 32", we_cnt - we0); end
    checks++; if (wr_log[qi] !== 5'd5) begin fails++; $display("FAIL full_first_addr got %0d want 5", wr_log[qi]); end
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== image(i)) bad++;
    checks++; if (bad != 0) begin fails++; $display("FAIL full_mem_intact got %0d changed words want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap_fwd();
    test_wrap();
    test_len0();
    test_start_busy();
    test_reset_mid();
    test_full_len32();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ram_block_copier.md
Name: ram_block_copier

Overview:
- Initiator-side master for the single-port 32x32 data RAM (combinational read, write on rising clk when we=1).
- Drives addr/we/datain and consumes dataout to copy a block of words from a source base to a destination base within the same RAM.
- Accumulates a wrapping checksum of the words it moves.
- Sits between the control FSM/test controller and the data RAM; owns the RAM port while busy.

Parameters:
- AW, 5, word-address width (RAM depth 2**AW = 32).
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- src_base  in  AW  first source word address.
- dst_base  in  AW  first destination word address.
- len  in  AW+1  word count, 0..32.
- busy  out  1  high in RD/WR states.
- done  out  1  one-cycle pulse on completion.
- checksum  out  DW  wrapping sum of words read in the last transfer; held until the next accepted start.
- ram_addr  out  32  RAM address, zero-extended from AW bits.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data, valid combinationally for the current ram_addr.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE.
  - busy=0, done=0, checksum=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - Reset mid-transfer aborts immediately. Words already written stay written; no further writes occur.
- States: IDLE, RD, WR, DONE.
- IDLE, start=1:
  - Latch src_base, dst_base, len. Clear checksum. Compute direction.
  - len=0 -> go to DONE (no RAM access). Otherwise -> RD.
- Direction:
  - Descending if ((dst_base - src_base) mod 32) != 0 and < len; ascending otherwise.
  - This makes overlapping copies behave as memmove.
  - Offset k starts at 0 (ascending) or len-1 (descending).
- RD (1 cycle):
  - ram_addr = (src+k) mod 32, ram_we=0.
  - At the edge: buf <= ram_rdata, checksum <= checksum + ram_rdata (mod 2**32). Go to WR.
- WR (1 cycle):
  - ram_addr = (dst+k) mod 32, ram_we=1, ram_wdata=buf.
  - At the edge: if this was the last word -> DONE; else step k (+1 or -1) -> RD.
- DONE (1 cycle): done=1, busy=0, ram_we=0. Next state IDLE.
- Latency: start accepted at edge E0; done is high for the cycle following edge E(2*len); 2 cycles per word.
- ram_we is asserted only in WR. In IDLE/DONE, ram_addr=0 and ram_we=0.
- start while busy or in DONE is ignored and not queued.
- Address arithmetic wraps modulo 32 on both source and destination.
- len>32 is not representable. len=32 with src==dst rewrites every word with its own value.
- Changes on src_base/dst_base/len after acceptance have no effect.

Decomposition:
- Shared package (mem_pkg):
  - AW=5, DW=32 constants.
  - State enum {IDLE, RD, WR, DONE}.
  - RAM port struct type (addr, we, wdata).
- Optional sub-module: ram_copy_addr_gen — holds k, direction, and last-word detect; outputs src/dst addresses. The FSM stays in the top module.

Test Plan:
All scenarios run against the RAM power-up image: ram[i]=i; ram[0x00]=0xBF800000; ram[0x14..0x17]=0xA3,0x27,0x79,0x115.
- Basic copy:
  - Stimulus: src=0x14, dst=0x00, len=4.
  - Response: ram[0..3]=0xA3,0x27,0x79,0x115; checksum=0x258; done pulses 8 cycles after start edge; exactly 4 we pulses, ascending addresses.
- Overlap forward:
  - Stimulus: src=0x02, dst=0x03, len=3.
  - Response: descending order (write addresses 5,4,3); ram[3..5]=2,3,4; ram[2]=2 unchanged; checksum=9.
- Wrap-around with overlap:
  - Stimulus: src=0x1E, dst=0x00, len=4.
  - Response: ram[0..3]=0x1E,0x1F,0xBF800000,0x01; checksum=0xBF80003E.
- len=0:
  - Stimulus: start with len=0.
  - Response: done high in the cycle after the start edge; busy never high; ram_we never high; checksum=0.
- Start while busy:
  - Stimulus: second start pulse with different bases during a len=4 copy.
  - Response: ignored; only the original 4 words are written; single done pulse.
- Reset mid-operation:
  - Stimulus: rst_n=0 for one edge while in WR of word 2.
  - Response: next cycle IDLE, busy=0, ram_we=0, checksum=0; words 0-1 written, word 2 not written.
